// File: rtl/nexus_mem_pkg.sv
// Shared types and constants for the NexusRV16 unified-memory arbiter.
// Owner codes double as the externally visible grant encoding.
package nexus_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_EXT  = 2'd1;
  localparam logic [1:0] OWN_DMEM = 2'd2;
  localparam logic [1:0] OWN_IMEM = 2'd3;

  localparam int MEM_ADDR_W = 15;

endpackage

// File: rtl/nexus_prio_sel.sv
// Three-way fixed-priority select (ext > dmem > imem) with a starvation
// override that lets a long-waiting fetch jump ahead of the data port.
module nexus_prio_sel
  import nexus_mem_pkg::*;
(
  input  logic       ext_req,
  input  logic       dmem_req,
  input  logic       imem_req,
  input  logic       starve,
  output logic [1:0] winner
);

  always_comb begin
    winner = OWN_NONE;
    if (ext_req)                winner = OWN_EXT;
    else if (imem_req && starve) winner = OWN_IMEM;
    else if (dmem_req)           winner = OWN_DMEM;
    else if (imem_req)           winner = OWN_IMEM;
  end

endmodule

// File: rtl/nexus_mem_arbiter.sv
// Serialises loader, data-port and fetch accesses onto the single 16-bit
// NexusRV16 memory; one access at a time, acked with a one-cycle pulse.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | arbitrate; latch winner's request into the memory-side regs
// ST_ISSUE | mem_en (and mem_we for writes) high for exactly this cycle
// ST_WAIT  | down-count read latency; capture mem_rdata at terminal count
// ST_DONE  | ack pulse to the owner, read data presented from rdata_q
module nexus_mem_arbiter
  import nexus_mem_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic [15:0]           ext_addr,
  input  logic [15:0]           ext_wdata,
  output logic                  ext_ack,
  output logic [15:0]           ext_rdata,
  input  logic                  dmem_req,
  input  logic                  dmem_we,
  input  logic [15:0]           dmem_addr,
  input  logic [15:0]           dmem_wdata,
  output logic                  dmem_ack,
  output logic [15:0]           dmem_rdata,
  input  logic                  imem_req,
  input  logic [15:0]           imem_addr,
  output logic                  imem_ack,
  output logic [15:0]           imem_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata,
  output logic                  busy,
  output logic [1:0]            owner
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  state_t        state;
  logic [1:0]    owner_q;
  logic [1:0]    winner;
  logic [2:0]    cnt;
  logic [SW-1:0] starve_cnt;
  logic          starve;
  logic          we_q;
  logic [15:0]   rdata_q;
  logic          sel_we;
  logic [15:0]   sel_addr;
  logic [15:0]   sel_wdata;

  // Memory is word-addressed, so byte-address bit 0 is intentionally dropped.
  logic unused_lsb;
  assign unused_lsb = ^{ext_addr[0], dmem_addr[0], imem_addr[0], sel_addr[0]};

  assign starve = (starve_cnt == SW'(STARVE_MAX));

  nexus_prio_sel u_prio (
    .ext_req  (ext_req),
    .dmem_req (dmem_req),
    .imem_req (imem_req),
    .starve   (starve),
    .winner   (winner)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    case (winner)
      OWN_EXT:  begin sel_we = ext_we;  sel_addr = ext_addr;  sel_wdata = ext_wdata;  end
      OWN_DMEM: begin sel_we = dmem_we; sel_addr = dmem_addr; sel_wdata = dmem_wdata; end
      OWN_IMEM: sel_addr = imem_addr;
      default:  ;
    endcase
  end

  assign busy       = (state != ST_IDLE);
  assign owner      = owner_q;
  assign ext_rdata  = rdata_q;
  assign dmem_rdata = rdata_q;
  assign imem_rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner_q    <= OWN_NONE;
      cnt        <= '0;
      starve_cnt <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ext_ack    <= 1'b0;
      dmem_ack   <= 1'b0;
      imem_ack   <= 1'b0;
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      ext_ack  <= 1'b0;
      dmem_ack <= 1'b0;
      imem_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          // ext wins leave the starvation count untouched
          if (!imem_req || winner == OWN_IMEM)
            starve_cnt <= '0;
          else if (winner == OWN_DMEM && !starve)
            starve_cnt <= starve_cnt + SW'(1);
          if (winner != OWN_NONE) begin
            owner_q   <= winner;
            we_q      <= sel_we;
            mem_en    <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr[15:1];
            mem_wdata <= sel_wdata;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= 3'(MEM_LAT);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            if (!we_q) rdata_q <= mem_rdata;
            ext_ack  <= (owner_q == OWN_EXT);
            dmem_ack <= (owner_q == OWN_DMEM);
            imem_ack <= (owner_q == OWN_IMEM);
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          owner_q <= OWN_NONE;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nexus_mem_arbiter.sv
// Directed bench for nexus_mem_arbiter with a behavioural memory that only
// drives valid read data in the exact latency cycle (0xDEAD otherwise).
module tb_nexus_mem_arbiter;

  localparam int LAT  = 2;
  localparam int SMAX = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        ext_req, ext_we;
  logic [15:0] ext_addr, ext_wdata;
  logic        ext_ack;
  logic [15:0] ext_rdata;
  logic        dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        mem_en, mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;
  logic [1:0]  owner;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nexus_mem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .ext_req    (ext_req),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_ack    (ext_ack),
    .ext_rdata  (ext_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .owner      (owner)
  );

  logic [15:0] mem_arr [0:511];
  logic [8:0]  raddr = '0;
  int          lc = 0;

  always @(posedge clk) begin
    if (mem_en) begin
      lc    <= LAT;
      raddr <= mem_addr[8:0];
      if (mem_we) mem_arr[mem_addr[8:0]] <= mem_wdata;
    end else if (lc > 0) begin
      lc <= lc - 1;
    end
  end
  assign mem_rdata = (lc == 1) ? mem_arr[raddr] : 16'hDEAD;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ack_of(input int who);
    case (who)
      1:       return ext_ack;
      2:       return dmem_ack;
      default: return imem_ack;
    endcase
  endfunction

  function automatic logic [15:0] rdata_of(input int who);
    case (who)
      1:       return ext_rdata;
      2:       return dmem_rdata;
      default: return imem_rdata;
    endcase
  endfunction

  task automatic set_req(input int who, input logic v);
    case (who)
      1:       ext_req  = v;
      2:       dmem_req = v;
      default: imem_req = v;
    endcase
  endtask

  // One isolated access: checks issue cycle, strobe width, latency, data, busy span.
  task automatic run_acc(input int who, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] exp_rd,
                         input string tag);
    int n, busy_n, en_n;
    case (who)
      1:       begin ext_we = we; ext_addr = addr; ext_wdata = wdata; end
      2:       begin dmem_we = we; dmem_addr = addr; dmem_wdata = wdata; end
      default: imem_addr = addr;
    endcase
    set_req(who, 1'b1);
    tick();
    chk({tag, "_issue_strobes"}, 32'({mem_en, mem_we}), 32'({1'b1, we}));
    chk({tag, "_issue_addr"}, 32'(mem_addr), 32'(addr[15:1]));
    chk({tag, "_owner"}, 32'(owner), 32'(who));
    if (we) chk({tag, "_issue_wdata"}, 32'(mem_wdata), 32'(wdata));
    n = 1; busy_n = int'(busy); en_n = 0;
    while (!ack_of(who) && n < 20) begin
      tick();
      n++;
      busy_n += int'(busy);
      en_n   += int'(mem_en);
    end
    chk({tag, "_ack_latency"}, 32'(n), 32'(2 + LAT));
    chk({tag, "_en_extra"}, 32'(en_n), 32'd0);
    if (!we) chk({tag, "_rdata"}, 32'(rdata_of(who)), 32'(exp_rd));
    set_req(who, 1'b0);
    tick();
    chk({tag, "_busy_span"}, 32'(busy_n), 32'(2 + LAT));
    chk({tag, "_back_idle"}, 32'({busy, owner, ext_ack, dmem_ack, imem_ack}), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e_at, d_at, i_at, dbl, g, nacks;
    logic [15:0] d_rd, i_rd;
    int gr [5];
    int exp_g [5] = '{2, 2, 2, 3, 2};

    rst = 1'b1;
    ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
    dmem_req = 0; dmem_we = 0; dmem_addr = '0; dmem_wdata = '0;
    imem_req = 0; imem_addr = '0;
    tick();
    tick();
    chk("rst_strobes", 32'({mem_en, mem_we, ext_ack, dmem_ack, imem_ack}), 32'd0);
    chk("rst_busy_owner", 32'({busy, owner}), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_rdata", 32'(dmem_rdata), 32'd0);
    rst = 1'b0;
    tick();

    run_acc(1, 1'b1, 16'h0100, 16'hA00A, 16'h0000, "ext_wr");
    run_acc(1, 1'b1, 16'h0050, 16'hFFAB, 16'h0000, "pre_28");
    run_acc(1, 1'b1, 16'h0102, 16'h1234, 16'h0000, "pre_81");
    run_acc(2, 1'b0, 16'h0050, 16'h0000, 16'hFFAB, "dmem_rd");
    run_acc(2, 1'b0, 16'h0101, 16'h0000, 16'hA00A, "dmem_rd_odd");

    // all three at once: ext, then dmem, then imem, 3+LAT apart
    ext_we = 1; ext_addr = 16'h0200; ext_wdata = 16'h5555;
    dmem_we = 0; dmem_addr = 16'h0050;
    imem_addr = 16'h0102;
    ext_req = 1; dmem_req = 1; imem_req = 1;
    e_at = 0; d_at = 0; i_at = 0; dbl = 0; d_rd = '0; i_rd = '0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (int'(ext_ack) + int'(dmem_ack) + int'(imem_ack) > 1) dbl++;
      if (ext_ack)  begin e_at = c; ext_req = 0; end
      if (dmem_ack) begin d_at = c; d_rd = dmem_rdata; dmem_req = 0; end
      if (imem_ack) begin i_at = c; i_rd = imem_rdata; imem_req = 0; end
    end
    chk("simul_ext_ack_cycle", 32'(e_at), 32'(2 + LAT));
    chk("simul_dmem_ack_cycle", 32'(d_at), 32'(2 + LAT + (3 + LAT)));
    chk("simul_imem_ack_cycle", 32'(i_at), 32'(2 + LAT + 2 * (3 + LAT)));
    chk("simul_double_ack", 32'(dbl), 32'd0);
    chk("simul_dmem_rdata", 32'(d_rd), 32'hFFAB);
    chk("simul_imem_rdata", 32'(i_rd), 32'h1234);

    // dmem and imem held continuously: imem forced through after 3 dmem wins
    dmem_we = 0; dmem_addr = 16'h0050; imem_addr = 16'h0102;
    dmem_req = 1; imem_req = 1;
    g = 0; nacks = 0;
    for (int c = 0; c < 60 && g < 5; c++) begin
      tick();
      nacks += int'(dmem_ack) + int'(imem_ack);
      if (mem_en) begin
        gr[g] = int'(owner);
        g++;
      end
    end
    dmem_req = 0; imem_req = 0;
    chk("starve_grant_count", 32'(g), 32'd5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("starve_grant%0d", i), 32'(gr[i]), 32'(exp_g[i]));
    chk("starve_acks_before_last", 32'(nacks), 32'd4);
    for (int i = 0; i < 6; i++) tick();
    chk("starve_idle", 32'(busy), 32'd0);

    // reset during WAIT of a dmem read
    dmem_we = 0; dmem_addr = 16'h0050; dmem_req = 1;
    tick();
    tick();
    chk("rstwait_in_wait", 32'({busy, owner}), 32'({1'b1, 2'd2}));
    rst = 1'b1;
    tick();
    rst = 1'b0; dmem_req = 0;
    chk("rstwait_idle", 32'({busy, owner}), 32'd0);
    chk("rstwait_rdata_cleared", 32'(dmem_rdata), 32'd0);
    nacks = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      nacks += int'(dmem_ack) + int'(ext_ack) + int'(imem_ack);
    end
    chk("rstwait_no_ack", 32'(nacks), 32'd0);

    run_acc(3, 1'b0, 16'h0103, 16'h0000, 16'h1234, "imem_odd");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
